// File: rtl/bit_framer_pkg.sv
// bit_framer_pkg: shared states and sizing constants for the audio bit framer
package bit_framer_pkg;
    localparam int WORD_W   = 32;
    localparam int LAST_PKT = 936;
    localparam int ADDR_W   = 10;
    localparam int CNT_W    = 5;
    typedef enum logic [1:0] {IDLE, RECORD, PRE, PLAY} state_t;
endpackage

// File: rtl/bit_framer_if.sv
// bit_framer_if: sample memory bus between the framer and the memory
interface bit_framer_if;
    import bit_framer_pkg::*;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] wr_data;
    logic [WORD_W-1:0] rd_data;
    modport master(output wr_en, rd_en, mem_addr, wr_data, input rd_data);
    modport slave(input wr_en, rd_en, mem_addr, wr_data, output rd_data);
endinterface

// File: rtl/bit_index_counter.sv
// bit_index_counter: 5-bit wrapping bit index with enable and synchronous clear
module bit_index_counter
    import bit_framer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] thirty_two_count
);
    // clear wins over count; natural wrap 31 -> 0
    always_ff @(posedge clk or negedge reset)
        if (!reset) thirty_two_count <= '0;
        else if (clr) thirty_two_count <= '0;
        else if (en) thirty_two_count <= thirty_two_count + 1'b1;
endmodule

// File: rtl/bit_framer.sv
// bit_framer: serial/parallel engine for audio record and playback
module bit_framer
    import bit_framer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              Rec_butt,
    input  logic              Play_butt,
    input  logic              serial_in,
    input  logic [ADDR_W-1:0] packets,
    output logic [CNT_W-1:0]  thirty_two_count,
    output logic              prepacket,
    output logic              serial_out,
    output logic              busy,
    bit_framer_if.master      mem
);
    state_t            st, st_n;
    logic [WORD_W-1:0] shreg, rd_word;
    logic              rd_pend, btn, wrap, end_pkt;

    assign btn        = Rec_butt | Play_butt;
    assign wrap       = thirty_two_count == CNT_W'(WORD_W - 1);
    assign end_pkt    = wrap && packets == ADDR_W'(LAST_PKT);
    assign busy       = st != IDLE;
    assign prepacket  = st == PRE;
    assign serial_out = st == PLAY && shreg[WORD_W-1];

    bit_index_counter u_cnt (
        .clk             (clk),
        .reset           (reset),
        .en              (st != IDLE),
        .clr             (btn),
        .thirty_two_count(thirty_two_count)
    );

    // state register
    always_ff @(posedge clk or negedge reset)
        if (!reset) st <= IDLE;
        else st <= st_n;

    // buttons restart from any state, record first; packets end at the last index
    always_comb begin
        st_n = st;
        if (Rec_butt) st_n = RECORD;
        else if (Play_butt) st_n = PRE;
        else if (wrap && st == PRE) st_n = PLAY;
        else if (end_pkt && (st == RECORD || st == PLAY)) st_n = IDLE;
    end

    // shifting, word assembly and memory strobes; address advances after each completed access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg        <= '0;
            rd_word      <= '0;
            rd_pend      <= 1'b0;
            mem.wr_en    <= 1'b0;
            mem.rd_en    <= 1'b0;
            mem.mem_addr <= '0;
            mem.wr_data  <= '0;
        end else begin
            mem.wr_en <= 1'b0;
            mem.rd_en <= 1'b0;
            rd_pend   <= !btn && mem.rd_en;
            if (btn) begin
                mem.mem_addr <= '0;
                mem.rd_en    <= !Rec_butt;
            end else begin
                if (mem.wr_en || rd_pend) mem.mem_addr <= mem.mem_addr + 1'b1;
                if (rd_pend) rd_word <= mem.rd_data;
                if (st == RECORD) begin
                    shreg <= {shreg[WORD_W-2:0], serial_in};
                    if (wrap) begin
                        mem.wr_data <= {shreg[WORD_W-2:0], serial_in};
                        mem.wr_en   <= 1'b1;
                    end
                end
                if (st == PRE && wrap) begin
                    shreg     <= rd_word;
                    mem.rd_en <= 1'b1;
                end
                if (st == PLAY) begin
                    shreg     <= wrap ? rd_word : shreg << 1;
                    mem.rd_en <= wrap && !end_pkt && (mem.mem_addr <= ADDR_W'(LAST_PKT));
                end
            end
        end
    end
endmodule

// File: tb/tb_bit_framer.sv
// tb_bit_framer: randomized scoreboard bench for bit_framer
module tb_bit_framer;
    import bit_framer_pkg::*;

    logic              clk = 0, reset = 0, Rec_butt = 0, Play_butt = 0, serial_in = 0;
    logic [ADDR_W-1:0] packets = '0;
    logic [CNT_W-1:0]  thirty_two_count;
    logic              prepacket, serial_out, busy;

    bit_framer_if bus();

    bit_framer dut (
        .clk             (clk),
        .reset           (reset),
        .Rec_butt        (Rec_butt),
        .Play_butt       (Play_butt),
        .serial_in       (serial_in),
        .packets         (packets),
        .thirty_two_count(thirty_two_count),
        .prepacket       (prepacket),
        .serial_out      (serial_out),
        .busy            (busy),
        .mem             (bus)
    );

    always #5 clk = ~clk;

    logic [WORD_W-1:0]        memv [0:(1<<ADDR_W)-1];
    logic [ADDR_W+WORD_W-1:0] wq[$];
    logic [ADDR_W-1:0]        rq[$];
    logic                     sq[$];
    int                       pq[$];
    int                       n_chk = 0, n_fail = 0, plen = 0;
    bit                       play_mode = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // memory: registered read, data presented the cycle after rd_en
    always @(negedge clk) if (bus.rd_en) bus.rd_data <= memv[bus.mem_addr];

    // monitor: pops expectations whenever the DUT presents an output
    always @(negedge clk) begin
        if (bus.wr_en) begin
            if (wq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_wr: addr %0d data %h with nothing expected", bus.mem_addr, bus.wr_data);
            end else begin
                chk("wr_addr_data", {bus.mem_addr, bus.wr_data}, wq.pop_front());
                chk("wr_rd_excl", bus.rd_en, 0);
            end
        end
        if (bus.rd_en) begin
            if (rq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_rd: addr %0d with nothing expected", bus.mem_addr);
            end else chk("rd_addr", bus.mem_addr, rq.pop_front());
        end
        if (play_mode && busy && !prepacket) begin
            if (sq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL serial_extra: got %b with no bit expected", serial_out);
            end else chk("serial_out", serial_out, sq.pop_front());
        end
        if (prepacket) plen++;
        else if (plen != 0) begin
            if (pq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL prepacket_unexp: length %0d with none expected", plen);
            end else chk("prepacket_len", plen, pq.pop_front());
            plen = 0;
        end
    end

    task automatic chk_zero(input string nm);
        chk({nm, "_count"}, thirty_two_count, 0);
        chk({nm, "_prepacket"}, prepacket, 0);
        chk({nm, "_wr_en"}, bus.wr_en, 0);
        chk({nm, "_rd_en"}, bus.rd_en, 0);
        chk({nm, "_mem_addr"}, bus.mem_addr, 0);
        chk({nm, "_wr_data"}, bus.wr_data, 0);
        chk({nm, "_serial_out"}, serial_out, 0);
        chk({nm, "_busy"}, busy, 0);
    endtask

    task automatic rec_start(input int hold);
        @(negedge clk) Rec_butt = 1;
        repeat (hold) begin
            @(negedge clk);
            chk("hold_count", thirty_two_count, 0);
        end
        Rec_butt = 0;
    endtask

    task automatic rec_words(input int n, input bit fin, input logic [WORD_W-1:0] first);
        for (int k = 0; k < n; k++) begin
            logic [WORD_W-1:0] w;
            w = (k == 0) ? first : $urandom();
            packets = (fin && k == n - 1) ? ADDR_W'(LAST_PKT) : ADDR_W'(k);
            wq.push_back({ADDR_W'(k), w});
            for (int b = 0; b < WORD_W; b++) begin
                serial_in = w[WORD_W-1-b];
                chk("rec_count", thirty_two_count, b);
                chk("rec_busy", busy, 1);
                @(negedge clk);
            end
        end
        if (fin) begin
            chk("rec_end_busy", busy, 0);
            repeat (3) begin
                @(negedge clk);
                chk("idle_count", thirty_two_count, 0);
            end
        end
    endtask

    task automatic play(input int npk, input int abort_pkt);
        for (int a = 0; a <= npk; a++) rq.push_back(ADDR_W'(a));
        for (int p = 0; p < npk; p++)
            for (int b = 0; b < WORD_W; b++) sq.push_back(memv[p][WORD_W-1-b]);
        pq.push_back(WORD_W);
        packets = '0;
        @(negedge clk) Play_butt = 1;
        play_mode = 1;
        @(negedge clk) Play_butt = 0;
        for (int b = 0; b < WORD_W; b++) begin
            chk("pre_count", thirty_two_count, b);
            chk("pre_flag", prepacket, 1);
            chk("pre_serial", serial_out, 0);
            @(negedge clk);
        end
        for (int p = 0; p < npk; p++) begin
            packets = (p == npk - 1) ? ADDR_W'(LAST_PKT) : ADDR_W'(p);
            for (int b = 0; b < WORD_W; b++) begin
                if (p == abort_pkt && b == 10) begin
                    play_mode = 0;
                    sq.delete();
                    rq.delete();
                    Rec_butt = 1;
                    Play_butt = 1;
                    @(negedge clk);
                    Rec_butt = 0;
                    Play_butt = 0;
                    chk("both_count", thirty_two_count, 0);
                    chk("both_prepacket", prepacket, 0);
                    chk("both_busy", busy, 1);
                    chk("both_rd_en", bus.rd_en, 0);
                    return;
                end
                chk("play_count", thirty_two_count, b);
                @(negedge clk);
            end
        end
        play_mode = 0;
        chk("play_end_busy", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) memv[i] = $urandom();
        memv[0] = 32'h8000_0001;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        reset = 1;
        rec_start(1);
        rec_words(1, 0, 32'hA5A5_0F0F);
        packets = 1;
        for (int b = 0; b < 17; b++) begin
            serial_in = 1'($urandom());
            chk("mid_count", thirty_two_count, b);
            @(negedge clk);
        end
        chk("mid_count", thirty_two_count, 17);
        reset = 0;
        #1 chk_zero("async_reset");
        @(negedge clk) reset = 1;
        repeat (40) @(negedge clk);
        chk("post_reset_busy", busy, 0);
        chk("post_reset_count", thirty_two_count, 0);
        play(3, -1);
        play(3, 1);
        rec_words(1, 1, $urandom());
        rec_start(1);
        for (int b = 0; b < 10; b++) begin
            serial_in = 1'($urandom());
            chk("pre_hold_count", thirty_two_count, b);
            @(negedge clk);
        end
        rec_start(3);
        rec_words(2, 1, $urandom());
        rec_start(1);
        rec_words(LAST_PKT + 1, 1, $urandom());
        repeat (5) @(negedge clk);
        chk("wq_empty", wq.size(), 0);
        chk("rq_empty", rq.size(), 0);
        chk("sq_empty", sq.size(), 0);
        chk("pq_empty", pq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bit_framer.md
Name: bit_framer

Overview:
- Generates the 5-bit bit index and prepacket flag that the packet counter consumes. Acts as the serial/parallel engine of the audio record/playback path.
- Record: shifts the 1-bit audio stream into 32-bit words and writes one word per packet to the sample memory.
- Playback: fetches 32-bit words from memory and serialises them, after one prepacket period used for the first fetch.
- Sits between the button synchronisers and sample memory on one side, and the packet counter on the other.

Parameters:
- WORD_W, 32, bits per packet; the bit index is 5 bits wide.
- LAST_PKT, 936, index of the final packet (937 packets per recording).
- ADDR_W, 10, memory address width.

Ports:
- clk  in  1  system clock; one audio bit per cycle.
- reset  in  1  asynchronous, active-low reset.
- Rec_butt  in  1  synchronised record request, level or pulse.
- Play_butt  in  1  synchronised playback request, level or pulse.
- serial_in  in  1  audio bit to record.
- packets  in  ADDR_W  current packet index from the packet counter.
- rd_data  in  32  memory read data, valid 1 cycle after rd_en.
- thirty_two_count  out  5  bit index within the packet, 0..31.
- prepacket  out  1  high for the entire prepacket period.
- wr_en  out  1  one-cycle memory write strobe.
- rd_en  out  1  one-cycle memory read strobe.
- mem_addr  out  ADDR_W  write/read address.
- wr_data  out  32  assembled word.
- serial_out  out  1  playback bit; MSB first.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0): state=IDLE and every output 0 (thirty_two_count, prepacket, wr_en, rd_en, mem_addr, wr_data, serial_out, busy). Shift register and rd_word cleared.
- FSM states: IDLE, RECORD, PRE, PLAY.
- Button priority in any state:
  - Rec_butt → RECORD on the next edge, with count=0 and mem_addr=0.
  - Otherwise Play_butt → PRE on the next edge, with count=0 and mem_addr=0.
  - If both are asserted, Rec_butt wins.
  - A button held over several cycles keeps restarting the state; count stays 0 until release.
- IDLE: count held at 0; all strobes 0; serial_out=0.
- Bit counter: count increments by 1 every cycle in RECORD, PRE and PLAY, wrapping 31→0. It never advances in IDLE.
- RECORD:
  - shreg <= {shreg[30:0], serial_in} every cycle.
  - At count==31: wr_data <= {shreg[30:0], serial_in} and wr_en=1 for one cycle. mem_addr holds the current packet index during the strobe, then increments.
  - At count==31 with packets==LAST_PKT: final write issued, then → IDLE. Memory is never written past LAST_PKT.
- PRE:
  - prepacket=1 for all 32 cycles; serial_out=0.
  - rd_en=1 at count==0 with mem_addr=0; rd_word captured on the next cycle.
  - At count==31: load shreg <= rd_word, set mem_addr=1, prepacket falls, → PLAY.
- PLAY:
  - serial_out = shreg[31]; shift left every cycle.
  - rd_en=1 at count==0 with the current mem_addr; mem_addr increments after capture.
  - At count==31: shreg <= next word. There is no gap between packets.
  - At count==31 with packets==LAST_PKT: → IDLE. The read that would fall past LAST_PKT is suppressed (no rd_en).
- Strobe registration: wr_en and rd_en are registered and never both high in the same cycle.
- Counter interface: count==31 pulses once per packet. packets is sampled only at count==31.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. No partial write completes.

Decomposition:
- Shared package holds:
  - state enum (IDLE, RECORD, PRE, PLAY)
  - WORD_W and LAST_PKT constants
  - count width constant (5)
- Sub-module bit_index_counter: 5-bit wrap counter with enable and synchronous clear, outputting thirty_two_count.

Test Plan:
- Record, short: reset release; Rec_butt pulse; serial_in = pattern 0xA5A5_0F0F MSB first → wr_en at cycle 32 of RECORD, wr_data=0xA5A50F0F, mem_addr=0.
- Record, full: force packets=936 at the 937th count==31 → last wr_en at mem_addr=936, then busy=0 and count stays 0.
- Playback start: memory word0=0x8000_0001; Play_butt pulse → prepacket high for exactly 32 cycles, rd_en at PRE count 0 with addr 0; serial_out then emits 1, thirty 0s, 1.
- Simultaneous buttons: Rec_butt and Play_butt high together in PLAY → RECORD next cycle, count=0, prepacket=0, no rd_en.
- Mid-record reset: reset=0 at count=17 → all outputs 0 asynchronously; after release, state IDLE and no wr_en until the next Rec_butt.
- Button restart: Rec_butt held 3 cycles → count remains 0 for those cycles and increments from the first cycle after release.
